// File: rtl/adsr_env.sv
// ADSR envelope generator with a free-running rate prescaler, saturating segment
// arithmetic, exact sustain clamping and legato or hard retriggering.
module adsr_env #(
    parameter int unsigned W  = 8,
    parameter int unsigned RW = 8,
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic [RW-1:0] ai,
    input  logic [RW-1:0] di,
    input  logic [W-1:0]  s,
    input  logic [RW-1:0] ri,
    input  logic [PW-1:0] presc,
    input  logic          hard_retrig,
    output logic [W-1:0]  envelope,
    output logic [2:0]    state,
    output logic          active
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ATTACK  = 3'd1;
    localparam logic [2:0] DECAY   = 3'd2;
    localparam logic [2:0] SUSTAIN = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam logic [W:0]   MAX_EXT = {1'b0, {W{1'b1}}};
    localparam logic [W-1:0] MAX     = {W{1'b1}};

    logic [PW-1:0] cnt;
    logic          trig_q;
    logic          tick;
    logic          rise;
    logic          gate_off;

    logic [W:0]    env_ext;
    logic [W:0]    ai_ext;
    logic [W:0]    di_ext;
    logic [W:0]    ri_ext;
    logic [W:0]    att_sum;
    logic [W:0]    dec_diff;
    logic [W:0]    rel_diff;

    logic [W-1:0]  env_nxt;
    logic [2:0]    state_nxt;

    assign tick     = (cnt == presc);
    assign rise     = trig & ~trig_q;
    assign gate_off = ~trig & ((state == ATTACK) | (state == DECAY) | (state == SUSTAIN));

    assign env_ext  = {1'b0, envelope};
    assign ai_ext   = {{(W + 1 - RW){1'b0}}, ai};
    assign di_ext   = {{(W + 1 - RW){1'b0}}, di};
    assign ri_ext   = {{(W + 1 - RW){1'b0}}, ri};

    // One spare bit: carry flags attack overflow, borrow flags decay/release underflow.
    assign att_sum  = env_ext + ai_ext;
    assign dec_diff = env_ext - di_ext;
    assign rel_diff = env_ext - ri_ext;

    assign active   = (state != IDLE);

    always_comb begin
        env_nxt   = envelope;
        state_nxt = state;
        if (rise) begin
            state_nxt = ATTACK;
            if (hard_retrig) begin
                env_nxt = '0;
            end
        end else if (gate_off) begin
            state_nxt = RELEASE;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    env_nxt = envelope;
                end
                ATTACK: begin
                    if ((ai == '0) || (att_sum >= MAX_EXT)) begin
                        env_nxt   = MAX;
                        state_nxt = DECAY;
                    end else begin
                        env_nxt = att_sum[W-1:0];
                    end
                end
                DECAY: begin
                    if ((di == '0) || dec_diff[W] || (dec_diff[W-1:0] <= s)) begin
                        env_nxt   = s;
                        state_nxt = SUSTAIN;
                    end else begin
                        env_nxt = dec_diff[W-1:0];
                    end
                end
                SUSTAIN: begin
                    env_nxt = s;
                end
                RELEASE: begin
                    if ((ri == '0) || rel_diff[W] || (rel_diff[W-1:0] == '0)) begin
                        env_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        env_nxt = rel_diff[W-1:0];
                    end
                end
                default: begin
                    env_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            envelope <= '0;
            state    <= IDLE;
            cnt      <= '0;
            // A gate already high through reset must not count as a note-on afterwards.
            trig_q   <= trig;
        end else begin
            envelope <= env_nxt;
            state    <= state_nxt;
            cnt      <= tick ? '0 : cnt + 1'b1;
            trig_q   <= trig;
        end
    end

endmodule

// File: tb/tb_adsr_env.sv
// Self-checking bench for adsr_env: directed scenarios plus randomized gate/rate
// traffic compared every clock against an integer-arithmetic reference model.
module tb_adsr_env;

    localparam int W   = 8;
    localparam int RW  = 8;
    localparam int PW  = 8;
    localparam int MAX = (1 << W) - 1;

    logic          clk;
    logic          rst;
    logic          trig;
    logic [RW-1:0] ai;
    logic [RW-1:0] di;
    logic [W-1:0]  s;
    logic [RW-1:0] ri;
    logic [PW-1:0] presc;
    logic          hard_retrig;
    logic [W-1:0]  envelope;
    logic [2:0]    state;
    logic          active;

    int checks;
    int failures;

    // Reference model: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
    int m_env;
    int m_state;
    int m_cnt;
    int m_trigq;

    adsr_env #(
        .W (W),
        .RW(RW),
        .PW(PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .ai         (ai),
        .di         (di),
        .s          (s),
        .ri         (ri),
        .presc      (presc),
        .hard_retrig(hard_retrig),
        .envelope   (envelope),
        .state      (state),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  e;
        bit  tick;
        bit  rise;
        if (rst) begin
            m_env   = 0;
            m_state = 0;
            m_cnt   = 0;
            m_trigq = int'(trig);
            return;
        end
        tick    = (m_cnt == int'(presc));
        rise    = trig && (m_trigq == 0);
        m_trigq = int'(trig);
        m_cnt   = tick ? 0 : (m_cnt + 1) % (1 << PW);
        if (rise) begin
            m_state = 1;
            if (hard_retrig) m_env = 0;
        end else if (!trig && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else if (tick) begin
            case (m_state)
                1: begin
                    e = m_env + int'(ai);
                    if (ai == 0 || e >= MAX) begin
                        m_env = MAX; m_state = 2;
                    end else m_env = e;
                end
                2: begin
                    e = m_env - int'(di);
                    if (di == 0 || e <= int'(s)) begin
                        m_env = int'(s); m_state = 3;
                    end else m_env = e;
                end
                3: m_env = int'(s);
                4: begin
                    e = m_env - int'(ri);
                    if (ri == 0 || e <= 0) begin
                        m_env = 0; m_state = 0;
                    end else m_env = e;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("env", 32'(envelope), m_env);
        check("state", 32'(state), m_state);
        check("active", 32'(active), (m_state != 0) ? 1 : 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int exp_att [4];
        checks      = 0;
        failures    = 0;
        m_env       = 0;
        m_state     = 0;
        m_cnt       = 0;
        m_trigq     = 0;
        rst         = 1'b1;
        trig        = 1'b0;
        ai          = 8'd64;
        di          = 8'd16;
        s           = 8'd128;
        ri          = 8'd32;
        presc       = 8'd0;
        hard_retrig = 1'b0;
        run(2);
        check("reset_env", 32'(envelope), 0);
        check("reset_active", 32'(active), 0);
        rst = 1'b0;
        run(2);

        // Full ADSR cycle with tick every clock.
        exp_att = '{64, 128, 192, 255};
        trig = 1'b1;
        cycle();
        check("rise_env", 32'(envelope), 0);
        check("rise_state", 32'(state), 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("attack_env", 32'(envelope), exp_att[i]);
        end
        check("attack_done_state", 32'(state), 2);
        run(10);
        check("sustain_env", 32'(envelope), 128);
        check("sustain_state", 32'(state), 3);
        trig = 1'b0;
        cycle();
        check("gate_off_hold", 32'(envelope), 128);
        check("gate_off_state", 32'(state), 4);
        run(4);
        check("release_end_env", 32'(envelope), 0);
        check("release_end_state", 32'(state), 0);

        // Zero rates: every segment is instant.
        ai = 0; di = 0; ri = 0; s = 8'd77;
        trig = 1'b1;
        run(2);
        check("inst_attack", 32'(envelope), 255);
        cycle();
        check("inst_decay", 32'(envelope), 77);
        trig = 1'b0;
        run(2);
        check("inst_release", 32'(envelope), 0);
        check("inst_release_state", 32'(state), 0);

        // Legato then hard retrigger from release.
        s = 8'd100;
        trig = 1'b1;
        run(3);
        trig = 1'b0;
        cycle();
        check("rel_at_100", 32'(envelope), 100);
        trig = 1'b1;
        cycle();
        check("legato_env", 32'(envelope), 100);
        check("legato_state", 32'(state), 1);
        ai = 8'd10;
        cycle();
        check("legato_step", 32'(envelope), 110);
        trig = 1'b0;
        cycle();
        trig = 1'b1; hard_retrig = 1'b1;
        cycle();
        check("hard_env", 32'(envelope), 0);
        check("hard_state", 32'(state), 1);

        // Reset mid-attack, gate left high.
        hard_retrig = 1'b0;
        trig = 1'b0;
        run(2);
        ai = 8'd50;
        trig = 1'b1;
        run(4);
        check("pre_reset_env", 32'(envelope), 150);
        rst = 1'b1;
        cycle();
        check("mid_reset_env", 32'(envelope), 0);
        check("mid_reset_active", 32'(active), 0);
        rst = 1'b0;
        run(3);
        check("no_retrig_after_reset", 32'(state), 0);

        // Sustain at full scale, then live sustain change.
        trig = 1'b0;
        cycle();
        ai = 0; di = 8'd5; s = 8'd255;
        trig = 1'b1;
        run(3);
        check("full_sustain_env", 32'(envelope), 255);
        check("full_sustain_state", 32'(state), 3);
        s = 8'd100;
        cycle();
        check("live_sustain", 32'(envelope), 100);

        // Prescaled stepping and lowering presc below the running count.
        trig = 1'b0; ri = 0;
        run(2);
        presc = 8'd3; ai = 8'd10; di = 8'd3; s = 8'd200;
        trig = 1'b1;
        run(60);
        presc = 8'd200;
        run(150);
        presc = 8'd3;
        run(300);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                trig = ~trig;
                hard_retrig = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 31) == 0) ai = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            if ($urandom_range(0, 31) == 0) di = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
            if ($urandom_range(0, 31) == 0) ri = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
            if ($urandom_range(0, 63) == 0) s = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            if ($urandom_range(0, 99) == 0) presc = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
